// File: rtl/au_gray_cnt_arb.sv
// au_gray_cnt_arb: round-robin arbitrated bank of Gray counters sharing one Gray incrementer
//   AU_inc_gray_c ports: a (Gray in), ci (increment enable), z (Gray a+ci), co (binary carry out)
//   au_gray_cnt_arb ports: clk, rst_n (async active-low), en (global enable), req/clr (per channel),
//   gnt (one-hot grant, combinational), cnt (NCH packed Gray counters), wrap (registered wrap pulse)
module AU_inc_gray_c #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] z,
    output logic             co
);
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s;
    // Gray to binary is a suffix XOR from the MSB down
    always_comb begin
        b = a;
        if (ARCH == 0) begin
            for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ a[i];
        end else begin
            for (int d = 1; d < WIDTH; d = d * 2) b = b ^ (b >> d);
        end
    end
    // c[i] is the carry into bit i: ci AND all lower binary bits, built as a prefix AND
    always_comb begin
        c = (b << 1) | WIDTH'(ci);
        if (ARCH == 0) begin
            for (int i = 1; i < WIDTH; i++) c[i] = c[i] & c[i-1];
        end else if (ARCH == 1) begin
            for (int d = 1; d < WIDTH; d = d * 2) c = c & ((c << d) | ((WIDTH'(1) << d) - WIDTH'(1)));
        end else begin
            for (int l = 0; (1 << l) < WIDTH; l++)
                for (int i = 0; i < WIDTH; i++)
                    if (((i >> l) & 1) == 1) c[i] = c[i] & c[((i >> l) << l) - 1];
        end
    end
    assign s  = b ^ c;
    assign z  = s ^ (s >> 1);
    assign co = c[WIDTH-1] & b[WIDTH-1];
endmodule

module au_gray_cnt_arb #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int ARCH  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       clr,
    output logic [NCH-1:0]       gnt,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       wrap
);
    localparam int PW = $clog2(NCH);
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NCH*WIDTH-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]       wrap_q, wrap_d;
    logic [NCH-1:0]       elig;
    logic [WIDTH-1:0]     inc_a, inc_z;
    logic                 inc_co;
    // rst_n gates eligibility so no grant is shown while reset is held
    always_comb begin
        elig  = req & ~clr & {NCH{en & rst_n}};
        gnt   = '0;
        inc_a = '0;
        ptr_d = ptr_q;
        // descending scan: the candidate nearest ptr is assigned last and wins
        for (int i = NCH - 1; i >= 0; i--)
            if (elig[(int'(ptr_q) + i) % NCH]) gnt = NCH'(1) << ((int'(ptr_q) + i) % NCH);
        for (int k = 0; k < NCH; k++) begin
            if (gnt[k]) begin
                inc_a = cnt_q[k*WIDTH +: WIDTH];
                ptr_d = PW'((k + 1) % NCH);
            end
        end
    end
    AU_inc_gray_c #(.WIDTH(WIDTH), .ARCH(ARCH)) u_inc (
        .a  (inc_a),
        .ci (|gnt),
        .z  (inc_z),
        .co (inc_co)
    );
    // carry out of the shared incrementer marks the max-value to zero step
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = gnt & {NCH{inc_co}};
        for (int k = 0; k < NCH; k++)
            cnt_d[k*WIDTH +: WIDTH] = clr[k] ? '0 : gnt[k] ? inc_z : cnt_q[k*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end
    assign cnt  = cnt_q;
    assign wrap = wrap_q;
endmodule
